// File: rtl/pipe_sel_reg_pkg.sv
// Shared types and helpers for the selector/register-slice pipeline stage.
package pipe_sel_reg_pkg;

  // Occupancy of the 2-entry register slice: nothing, main only, main + skid.
  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_MAIN  = 2'd1,
    SB_FULL  = 2'd2
  } skid_state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// WIDTH-bit 2-entry valid/ready register slice with flush; in_ready comes straight from state.
module pipe_skid_buf
  import pipe_sel_reg_pkg::*;
#(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_e      r_state;
  skid_state_e      w_state_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_load_in;
  logic             w_load_skid;
  logic             w_fill_skid;
  logic [WIDTH-1:0] r_main_p1;
  logic [WIDTH-1:0] r_skid_p1;

  assign in_ready  = (r_state != SB_FULL);
  assign out_valid = (r_state != SB_EMPTY);
  assign out_data  = r_main_p1;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_in   = 1'b0;
    w_load_skid = 1'b0;
    w_fill_skid = 1'b0;
    case (r_state)
      SB_EMPTY: begin
        if (w_push) begin
          w_state_nxt = SB_MAIN;
          w_load_in   = 1'b1;
        end
      end
      SB_MAIN: begin
        if (w_push && w_pop) begin
          w_load_in = 1'b1;
        end else if (w_push) begin
          w_state_nxt = SB_FULL;
          w_fill_skid = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = SB_EMPTY;
        end
      end
      SB_FULL: begin
        // in_ready is low here, so a pop can only refill main from the skid entry
        if (w_pop) begin
          w_state_nxt = SB_MAIN;
          w_load_skid = 1'b1;
        end
      end
      default: w_state_nxt = SB_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_state <= SB_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stage p1: main register drives the output; it returns to RESET_VAL on reset or flush
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_main_p1 <= RESET_VAL;
    end else if (w_load_in) begin
      r_main_p1 <= in_data;
    end else if (w_load_skid) begin
      r_main_p1 <= r_skid_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_skid) begin
      r_skid_p1 <= in_data;
    end
  end

endmodule

// File: rtl/pipe_sel_reg.sv
// N:1 operand select with range check and sticky error flag, registered through a skid slice.
module pipe_sel_reg
  import pipe_sel_reg_pkg::*;
#(
  parameter int               WIDTH       = 5,
  parameter int               NUM_IN      = 2,
  parameter int               DEFAULT_IDX = 0,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  localparam int              SEL_W       = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    sel_err
);

  logic [WIDTH-1:0] w_sel_data_p0;
  logic             w_sel_oor_p0;
  logic             r_sel_err;

  // Stage p0: combinational select; out-of-range indices fall back to DEFAULT_IDX
  always_comb begin
    w_sel_data_p0 = in_data[DEFAULT_IDX*WIDTH +: WIDTH];
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        w_sel_data_p0 = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_sel_oor_p0 = (32'(sel) >= 32'(NUM_IN));

  // Flushed words are dropped, so they must not raise the error either
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sel_err <= 1'b0;
    end else if (!flush && in_valid && in_ready && w_sel_oor_p0) begin
      r_sel_err <= 1'b1;
    end
  end

  assign sel_err = r_sel_err;

  pipe_skid_buf #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_data  (w_sel_data_p0),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

endmodule
